// File: rtl/mbinit_val_pattern_comparator.sv
// Valid-lane pattern comparator for MBINIT: counts iterations matching PATTERN,
// tracks the longest consecutive-match run, and logs a pass/fail result.
//
// state   | meaning
// IDLE    | waiting for i_enable; counters keep the last test's values
// COMPARE | sampling valid iterations until ITERATIONS have been counted
// DONE    | result and done held while i_enable stays high
module mbinit_val_pattern_comparator #(
    parameter logic [7:0] PATTERN    = 8'hF0,
    parameter int         ITERATIONS = 128,
    parameter int         CONSEC_REQ = 16
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       i_enable,
    input  logic       i_enable_16_iterations,
    input  logic [7:0] i_rx_val_data,
    input  logic       i_rx_val_vld,
    output logic       o_VAL_Result_logged,
    output logic       o_compare_done,
    output logic [7:0] o_match_count,
    output logic [7:0] o_max_consec
);

    localparam logic [7:0] ITER_LAST  = 8'(ITERATIONS);
    localparam logic [7:0] CONSEC_THR = 8'(CONSEC_REQ);

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] iter_cnt, iter_nxt;
    logic [7:0] consec_cnt, consec_nxt;
    logic [7:0] match_nxt, max_nxt;
    logic       result_nxt, done_nxt;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state               <= IDLE;
            iter_cnt            <= 8'd0;
            consec_cnt          <= 8'd0;
            o_match_count       <= 8'd0;
            o_max_consec        <= 8'd0;
            o_VAL_Result_logged <= 1'b0;
            o_compare_done      <= 1'b0;
        end else begin
            state               <= state_nxt;
            iter_cnt            <= iter_nxt;
            consec_cnt          <= consec_nxt;
            o_match_count       <= match_nxt;
            o_max_consec        <= max_nxt;
            o_VAL_Result_logged <= result_nxt;
            o_compare_done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        iter_nxt   = iter_cnt;
        consec_nxt = consec_cnt;
        match_nxt  = o_match_count;
        max_nxt    = o_max_consec;
        result_nxt = o_VAL_Result_logged;
        done_nxt   = o_compare_done;

        case (state)
            IDLE: begin
                if (i_enable) begin
                    state_nxt  = COMPARE;
                    iter_nxt   = 8'd0;
                    consec_nxt = 8'd0;
                    match_nxt  = 8'd0;
                    max_nxt    = 8'd0;
                    result_nxt = 1'b0;
                    done_nxt   = 1'b0;
                end
            end
            COMPARE: begin
                // Abort has priority, even over the final iteration.
                if (!i_enable) begin
                    state_nxt  = IDLE;
                    result_nxt = 1'b0;
                    done_nxt   = 1'b0;
                end else if (i_rx_val_vld && (iter_cnt < ITER_LAST)) begin
                    iter_nxt = iter_cnt + 8'd1;
                    if (i_rx_val_data == PATTERN) begin
                        consec_nxt = consec_cnt + 8'd1;
                        match_nxt  = o_match_count + 8'd1;
                    end else begin
                        consec_nxt = 8'd0;
                    end
                    if (consec_nxt > o_max_consec) begin
                        max_nxt = consec_nxt;
                    end
                    // Pass mode is sampled only on the final iteration.
                    if (iter_nxt == ITER_LAST) begin
                        state_nxt  = DONE;
                        done_nxt   = 1'b1;
                        result_nxt = i_enable_16_iterations ? (max_nxt >= CONSEC_THR)
                                                            : (match_nxt == ITER_LAST);
                    end
                end
            end
            DONE: begin
                if (!i_enable) begin
                    state_nxt  = IDLE;
                    result_nxt = 1'b0;
                    done_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mbinit_val_pattern_comparator.sv
// Scoreboard bench for mbinit_val_pattern_comparator: streams are modelled as
// arrays, expected results are queued at launch and checked when done rises.
module tb_mbinit_val_pattern_comparator;

    localparam logic [7:0] PAT = 8'hF0;
    localparam int         NIT = 128;
    localparam int         NCONS = 16;

    logic       CLK = 1'b0;
    logic       rst;
    logic       i_enable;
    logic       i_enable_16_iterations;
    logic [7:0] i_rx_val_data;
    logic       i_rx_val_vld;
    logic       o_VAL_Result_logged;
    logic       o_compare_done;
    logic [7:0] o_match_count;
    logic [7:0] o_max_consec;

    always #5 CLK = ~CLK;

    mbinit_val_pattern_comparator dut (
        .CLK                    (CLK),
        .rst                    (rst),
        .i_enable               (i_enable),
        .i_enable_16_iterations (i_enable_16_iterations),
        .i_rx_val_data          (i_rx_val_data),
        .i_rx_val_vld           (i_rx_val_vld),
        .o_VAL_Result_logged    (o_VAL_Result_logged),
        .o_compare_done         (o_compare_done),
        .o_match_count          (o_match_count),
        .o_max_consec           (o_max_consec)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   done_cyc;
        logic res;
        int   mc;
        int   mx;
    } exp_t;

    exp_t sb_q[$];

    logic       vld_a [0:511];
    logic [7:0] dat_a [0:511];
    logic       mode_a[0:511];
    int         n_slots;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the first `upto` slots and score the valid iterations.
    function automatic void model(input int upto, output int vc, output int mc,
                                  output int mx, output int done_slot);
        int run;
        run = 0; vc = 0; mc = 0; mx = 0; done_slot = -1;
        for (int s = 0; s < upto && done_slot < 0; s++) begin
            if (vld_a[s]) begin
                vc++;
                if (dat_a[s] == PAT) begin
                    mc++;
                    run++;
                    if (run > mx) mx = run;
                end else begin
                    run = 0;
                end
                if (vc == NIT) done_slot = s;
            end
        end
    endfunction

    logic prev_done = 1'b0;
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (o_compare_done && !prev_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("result", int'(o_VAL_Result_logged), int'(e.res));
                chk("match_count", int'(o_match_count), e.mc);
                chk("max_consec", int'(o_max_consec), e.mx);
            end
        end
        prev_done = o_compare_done;
    end

    task automatic fill_const(input int n, input logic mode);
        n_slots = n;
        for (int s = 0; s < n; s++) begin
            vld_a[s] = 1'b1; dat_a[s] = PAT; mode_a[s] = mode;
        end
    endtask

    task automatic run_stream(input int abort_slot);
        int   vc, mc, mx, ds, start;
        exp_t e;
        @(posedge CLK); #1;
        i_enable = 1'b0; i_rx_val_vld = 1'b0;
        @(posedge CLK); #1;
        i_enable = 1'b1;
        start = cyc;
        model((abort_slot < 0) ? n_slots : abort_slot, vc, mc, mx, ds);
        if (abort_slot < 0) begin
            e.done_cyc = start + ds + 2;
            e.mc  = mc;
            e.mx  = mx;
            e.res = mode_a[ds] ? (mx >= NCONS) : (mc == NIT);
            sb_q.push_back(e);
        end
        for (int s = 0; s < n_slots; s++) begin
            @(posedge CLK); #1;
            if (s == abort_slot) i_enable = 1'b0;
            i_rx_val_vld = vld_a[s];
            i_rx_val_data = dat_a[s];
            i_enable_16_iterations = mode_a[s];
        end
        // Extra traffic after the end must not disturb the held outputs.
        repeat (3) begin
            @(posedge CLK); #1;
            i_rx_val_vld = 1'($urandom_range(1));
            i_rx_val_data = 8'($urandom);
            i_enable_16_iterations = ~i_enable_16_iterations;
        end
        @(negedge CLK);
        chk("scoreboard_drained", sb_q.size(), 0);
        sb_q.delete();
        if (abort_slot < 0) begin
            chk("hold_done", int'(o_compare_done), 1);
            chk("hold_result", int'(o_VAL_Result_logged), int'(e.res));
            chk("hold_match", int'(o_match_count), mc);
            chk("hold_max", int'(o_max_consec), mx);
        end else begin
            chk("abort_done", int'(o_compare_done), 0);
            chk("abort_result", int'(o_VAL_Result_logged), 0);
            chk("abort_match_kept", int'(o_match_count), mc);
            chk("abort_max_kept", int'(o_max_consec), mx);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; i_enable = 1'b1; i_enable_16_iterations = 1'b1;
        i_rx_val_vld = 1'b1; i_rx_val_data = PAT;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_done", int'(o_compare_done), 0);
        chk("rst_result", int'(o_VAL_Result_logged), 0);
        chk("rst_match", int'(o_match_count), 0);
        chk("rst_max", int'(o_max_consec), 0);
        @(posedge CLK); #1;
        rst = 1'b0; i_enable = 1'b0;

        // 128 back-to-back matches, consecutive mode
        fill_const(NIT, 1'b1);
        run_stream(-1);

        // single mismatch after 20 matches
        fill_const(NIT, 1'b1);
        dat_a[20] = 8'h0F;
        run_stream(-1);

        // mismatch every 15th iteration, both modes
        for (int m = 0; m < 2; m++) begin
            fill_const(NIT, 1'(m));
            for (int s = 14; s < NIT; s += 15) dat_a[s] = 8'h00;
            run_stream(-1);
        end

        // 50% valid duty, junk data on idle slots
        n_slots = 2 * NIT;
        for (int s = 0; s < n_slots; s++) begin
            vld_a[s] = 1'(s % 2);
            dat_a[s] = vld_a[s] ? PAT : 8'h5A;
            mode_a[s] = 1'b1;
        end
        run_stream(-1);

        // abort at iteration 60, then a fresh run must start from zero
        fill_const(NIT, 1'b1);
        run_stream(60);
        fill_const(NIT, 1'b0);
        dat_a[100] = 8'h12;
        run_stream(-1);

        // reset while in DONE
        @(posedge CLK); #1;
        rst = 1'b1;
        @(posedge CLK); #1;
        rst = 1'b0; i_enable = 1'b0;
        @(negedge CLK);
        chk("rst_in_done_done", int'(o_compare_done), 0);
        chk("rst_in_done_result", int'(o_VAL_Result_logged), 0);
        chk("rst_in_done_match", int'(o_match_count), 0);
        chk("rst_in_done_max", int'(o_max_consec), 0);

        // enable drops on the 128th iteration: abort wins
        fill_const(NIT, 1'b0);
        run_stream(NIT - 1);

        // randomized streams
        for (int t = 0; t < 8; t++) begin
            int dens, err, vc;
            dens = $urandom_range(40, 100);
            err  = (t % 2 == 0) ? 0 : $urandom_range(1, 12);
            vc = 0;
            n_slots = 0;
            while (vc < NIT || n_slots < 1) begin
                vld_a[n_slots] = ($urandom_range(99) < dens) || (n_slots >= 400);
                dat_a[n_slots] = ($urandom_range(99) < err) ? 8'($urandom) : PAT;
                mode_a[n_slots] = 1'($urandom_range(1));
                if (vld_a[n_slots]) vc++;
                n_slots++;
            end
            for (int k = 0; k < 2; k++) begin
                vld_a[n_slots] = 1'b1;
                dat_a[n_slots] = 8'($urandom);
                mode_a[n_slots] = 1'($urandom_range(1));
                n_slots++;
            end
            run_stream(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
